// File: rtl/fetch_pkg.sv
// Shared fetch definitions: instruction constants, controller select encodings
// (pc_sel / instr_sel, also used by the controller) and the fetch FSM state type.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // pc_sel encodings
  localparam logic [1:0] PC_SEL_NEXT     = 2'b00;
  localparam logic [1:0] PC_SEL_REDIRECT = 2'b01;
  localparam logic [1:0] PC_SEL_HOLD     = 2'b10;
  localparam logic [1:0] PC_SEL_NEXT_ALT = 2'b11;

  // instr_sel encodings
  localparam logic [1:0] INSTR_SEL_TAKE   = 2'b00;
  localparam logic [1:0] INSTR_SEL_REPLAY = 2'b01;
  localparam logic [1:0] INSTR_SEL_FLUSH  = 2'b10;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_rsp_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC while the
// pipeline is frozen.
// Ports: clk, rst (sync, active-low), push/pop/clear controls,
//        push_instr/push_pc write data, full flag, instr/pc stored entry.
// Priority: clear > push > pop.
module fetch_rsp_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      full  <= 1'b0;
      instr <= NOP;
      pc    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= push_instr;
      pc    <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, issues single-outstanding instruction-memory
// requests and feeds pc_ID/instr_ID to decode.
// Ports: clk, rst (sync, active-low); controller pc_sel/instr_sel/target_pc,
//        pipe_stall; imem bus im_req_valid/im_req_ready/im_addr,
//        im_rsp_valid/im_rsp_data; fetch_stall, pc_ID, instr_ID;
//        perf_fetch/perf_discard/perf_stall.
// Build option: FETCH_PERF_CNT_EN adds saturating performance counters;
//               without it the perf outputs are tied to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_sel,
  input  logic [1:0]      instr_sel,
  input  logic [XLEN-1:0] target_pc,
  input  logic            pipe_stall,
  output logic            im_req_valid,
  input  logic            im_req_ready,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_rsp_valid,
  input  logic [XLEN-1:0] im_rsp_data,
  output logic            fetch_stall,
  output logic [XLEN-1:0] pc_ID,
  output logic [XLEN-1:0] instr_ID,
  output logic [XLEN-1:0] perf_fetch,
  output logic [XLEN-1:0] perf_discard,
  output logic [XLEN-1:0] perf_stall
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d;
  logic [XLEN-1:0] instr_id_q, instr_id_d;

  logic            buf_push, buf_pop, buf_clear, buf_full;
  logic [XLEN-1:0] buf_instr, buf_pc;

  logic            redirect, advance, req_fire, rsp_in, avail, consume;
  logic [XLEN-1:0] new_instr, new_pc;

  fetch_rsp_buf u_rsp_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (buf_push),
    .pop        (buf_pop),
    .clear      (buf_clear),
    .push_instr (im_rsp_data),
    .push_pc    (pc_q),
    .full       (buf_full),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

  assign redirect = (pc_sel == PC_SEL_REDIRECT);
  assign advance  = (pc_sel == PC_SEL_NEXT) || (pc_sel == PC_SEL_NEXT_ALT);

  // A held PC (load-use) also holds back the request.
  assign im_req_valid = (state_q == ISSUE) && (pc_sel != PC_SEL_HOLD);
  assign im_addr      = pc_q;
  assign req_fire     = im_req_valid && im_req_ready;

  // While the buffer is full there is no outstanding request, so the bus is ignored.
  assign rsp_in    = (state_q == WAIT) && !buf_full && im_rsp_valid;
  assign avail     = buf_full || rsp_in;
  assign new_instr = buf_full ? buf_instr : im_rsp_data;
  assign new_pc    = buf_full ? buf_pc : pc_q;
  assign consume   = avail && !pipe_stall && advance && (instr_sel == INSTR_SEL_TAKE);

  assign fetch_stall = !avail;

  // Next-state, PC, ID register and buffer control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    buf_push   = 1'b0;
    buf_pop    = 1'b0;
    buf_clear  = 1'b0;

    if (redirect) begin
      pc_d      = align_word(target_pc);
      buf_clear = 1'b1;
      if (!pipe_stall) instr_id_d = NOP;
      // Anything still in flight at the old address must be dropped.
      case (state_q)
        ISSUE:   state_d = req_fire ? DISCARD : ISSUE;
        WAIT:    state_d = (buf_full || im_rsp_valid) ? ISSUE : DISCARD;
        DISCARD: state_d = im_rsp_valid ? ISSUE : DISCARD;
        default: state_d = ISSUE;
      endcase
    end else begin
      if (!pipe_stall) begin
        case (instr_sel)
          INSTR_SEL_FLUSH:  instr_id_d = NOP;
          INSTR_SEL_REPLAY: instr_id_d = instr_id_q;
          default: begin
            if (consume) begin
              instr_id_d = new_instr;
              pc_id_d    = new_pc;
            end
          end
        endcase
      end

      case (state_q)
        BOOT:  state_d = ISSUE;
        ISSUE: if (req_fire) state_d = WAIT;
        WAIT: begin
          if (consume) begin
            pc_d    = pc_q + PC_STEP;
            buf_pop = buf_full;
            state_d = ISSUE;
          end else if (rsp_in) begin
            buf_push = 1'b1;
          end
        end
        DISCARD: if (im_rsp_valid) state_d = ISSUE;
        default: state_d = BOOT;
      endcase
    end
  end

  // State, PC and ID registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_id_q    <= '0;
      instr_id_q <= NOP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
    end
  end

  assign pc_ID    = pc_id_q;
  assign instr_ID = instr_id_q;

`ifdef FETCH_PERF_CNT_EN
  logic            drop_rsp;
  logic [XLEN-1:0] cnt_fetch_q, cnt_discard_q, cnt_stall_q;

  // Responses lost to a redirect: arriving in DISCARD, arriving alongside a
  // redirect, or sitting in the buffer when it is cleared.
  assign drop_rsp = ((state_q == DISCARD) && im_rsp_valid) ||
                    (redirect && (buf_full || rsp_in));

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_fetch_q   <= '0;
      cnt_discard_q <= '0;
      cnt_stall_q   <= '0;
    end else begin
      if (consume && (cnt_fetch_q != '1))    cnt_fetch_q   <= cnt_fetch_q + XLEN'(1);
      if (drop_rsp && (cnt_discard_q != '1)) cnt_discard_q <= cnt_discard_q + XLEN'(1);
      if (fetch_stall && (cnt_stall_q != '1)) cnt_stall_q  <= cnt_stall_q + XLEN'(1);
    end
  end

  assign perf_fetch   = cnt_fetch_q;
  assign perf_discard = cnt_discard_q;
  assign perf_stall   = cnt_stall_q;
`else
  assign perf_fetch   = '0;
  assign perf_discard = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a zero-wait instruction
// memory model (optional one extra cycle of latency) returning ~addr.
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [1:0]  instr_sel;
  logic [31:0] target_pc;
  logic        pipe_stall;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [31:0] im_addr;
  logic        im_rsp_valid;
  logic [31:0] im_rsp_data;
  logic        fetch_stall;
  logic [31:0] pc_ID;
  logic [31:0] instr_ID;
  logic [31:0] perf_fetch;
  logic [31:0] perf_discard;
  logic [31:0] perf_stall;

  int checks = 0;
  int errors = 0;

  logic        extra_lat = 1'b0;
  logic        slot_v    = 1'b0;
  logic [31:0] slot_d    = '0;

  logic [31:0] exp_fetch, exp_discard, exp_stall;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_sel       (pc_sel),
    .instr_sel    (instr_sel),
    .target_pc    (target_pc),
    .pipe_stall   (pipe_stall),
    .im_req_valid (im_req_valid),
    .im_req_ready (im_req_ready),
    .im_addr      (im_addr),
    .im_rsp_valid (im_rsp_valid),
    .im_rsp_data  (im_rsp_data),
    .fetch_stall  (fetch_stall),
    .pc_ID        (pc_ID),
    .instr_ID     (instr_ID),
    .perf_fetch   (perf_fetch),
    .perf_discard (perf_discard),
    .perf_stall   (perf_stall)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a;
  endfunction

  // One clock: sample handshake before the edge, drive the bus response after it.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    #3;
    fire = rst && im_req_valid && im_req_ready;
    a    = im_addr;
    @(posedge clk);
    #1;
    im_rsp_valid = 1'b0;
    if (!rst) begin
      slot_v = 1'b0;
    end else begin
      if (slot_v) begin
        im_rsp_valid = 1'b1;
        im_rsp_data  = slot_d;
        slot_v       = 1'b0;
      end
      if (fire) begin
        if (extra_lat) begin
          slot_v = 1'b1;
          slot_d = mem(a);
        end else begin
          im_rsp_valid = 1'b1;
          im_rsp_data  = mem(a);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_sel = 2'b00; instr_sel = 2'b00; target_pc = '0;
    pipe_stall = 1'b0; im_req_ready = 1'b1; im_rsp_valid = 1'b0; im_rsp_data = '0;
    tick(); tick();
    checks++; if (instr_ID !== NOP_W) begin errors++; $display("FAIL reset_instr: got %h exp %h", instr_ID, NOP_W); end
    checks++; if (pc_ID !== 32'h0) begin errors++; $display("FAIL reset_pc_id: got %h exp %h", pc_ID, 32'h0); end
    checks++; if (im_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b exp 0", im_req_valid); end
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL reset_fetch_stall: got %b exp 1", fetch_stall); end
    checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", im_addr); end
    checks++; if (perf_stall !== 32'h0) begin errors++; $display("FAIL reset_perf_stall: got %0d exp 0", perf_stall); end
  endtask

  task automatic test_fetch();
    rst = 1'b1;
    tick();  // BOOT -> ISSUE
    checks++; if (im_req_valid !== 1'b1 || im_addr !== 32'h0) begin errors++; $display("FAIL fetch_req0: got v=%b a=%h exp v=1 a=0", im_req_valid, im_addr); end
    tick();  // handshake, response in flight
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL fetch_rsp_stall: got %b exp 0", fetch_stall); end
    tick();  // ID loads
    checks++; if (instr_ID !== mem(32'h0) || pc_ID !== 32'h0) begin errors++; $display("FAIL fetch_id0: got %h@%h exp %h@0", instr_ID, pc_ID, mem(32'h0)); end
    checks++; if (im_addr !== 32'h4 || im_req_valid !== 1'b1) begin errors++; $display("FAIL fetch_req4: got v=%b a=%h exp v=1 a=4", im_req_valid, im_addr); end
    tick(); tick();
    checks++; if (instr_ID !== mem(32'h4) || pc_ID !== 32'h4) begin errors++; $display("FAIL fetch_id4: got %h@%h exp %h@4", instr_ID, pc_ID, mem(32'h4)); end
    checks++; if (im_addr !== 32'h8) begin errors++; $display("FAIL fetch_req8: got %h exp 8", im_addr); end
  endtask

  task automatic test_redirect();
    tick();  // request 8 accepted, response arrives now
    pc_sel = 2'b01; target_pc = 32'h0000_0102; instr_sel = 2'b10;
    tick();  // redirect wins over the arriving response
    pc_sel = 2'b00; instr_sel = 2'b00;
    checks++; if (instr_ID !== NOP_W || pc_ID !== 32'h4) begin errors++; $display("FAIL redir_flush: got %h@%h exp %h@4", instr_ID, pc_ID, NOP_W); end
    checks++; if (im_addr !== 32'h100 || im_req_valid !== 1'b1) begin errors++; $display("FAIL redir_addr: got v=%b a=%h exp v=1 a=100", im_req_valid, im_addr); end
    tick(); tick();
    checks++; if (instr_ID !== mem(32'h100) || pc_ID !== 32'h100) begin errors++; $display("FAIL redir_target: got %h@%h exp %h@100", instr_ID, pc_ID, mem(32'h100)); end
    // Redirect while the response is still outstanding -> DISCARD.
    extra_lat = 1'b1;
    tick();
    extra_lat = 1'b0;
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL wait_stall: got %b exp 1", fetch_stall); end
    pc_sel = 2'b01; target_pc = 32'h0000_0200;
    tick();
    pc_sel = 2'b00;
    checks++; if (im_req_valid !== 1'b0 || im_addr !== 32'h200) begin errors++; $display("FAIL discard_hold: got v=%b a=%h exp v=0 a=200", im_req_valid, im_addr); end
    checks++; if (fetch_stall !== 1'b1 || instr_ID !== NOP_W) begin errors++; $display("FAIL discard_id: got stall=%b id=%h exp 1 %h", fetch_stall, instr_ID, NOP_W); end
    tick();  // late response dropped
    checks++; if (im_req_valid !== 1'b1 || im_addr !== 32'h200) begin errors++; $display("FAIL discard_reissue: got v=%b a=%h exp v=1 a=200", im_req_valid, im_addr); end
    tick(); tick();
    checks++; if (instr_ID !== mem(32'h200) || pc_ID !== 32'h200) begin errors++; $display("FAIL discard_target: got %h@%h exp %h@200", instr_ID, pc_ID, mem(32'h200)); end
  endtask

  task automatic test_pipe_stall();
    tick();  // request 204, response arrives
    pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_ID !== mem(32'h200)) begin errors++; $display("FAIL stall_hold_id%0d: got %h exp %h", i, instr_ID, mem(32'h200)); end
      checks++; if (im_req_valid !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL stall_buf%0d: got v=%b stall=%b exp v=0 stall=0", i, im_req_valid, fetch_stall); end
    end
    pipe_stall = 1'b0;
    tick();  // drain buffer
    checks++; if (instr_ID !== mem(32'h204) || pc_ID !== 32'h204) begin errors++; $display("FAIL stall_drain: got %h@%h exp %h@204", instr_ID, pc_ID, mem(32'h204)); end
    checks++; if (im_addr !== 32'h208 || im_req_valid !== 1'b1) begin errors++; $display("FAIL stall_next: got v=%b a=%h exp v=1 a=208", im_req_valid, im_addr); end
  endtask

  task automatic test_load_use();
    pc_sel = 2'b10; instr_sel = 2'b01;
    #1;
    checks++; if (im_req_valid !== 1'b0) begin errors++; $display("FAIL lu_no_req: got %b exp 0", im_req_valid); end
    tick();
    pc_sel = 2'b00; instr_sel = 2'b00;
    checks++; if (instr_ID !== mem(32'h204) || pc_ID !== 32'h204 || im_addr !== 32'h208) begin errors++; $display("FAIL lu_hold: got %h@%h a=%h exp %h@204 a=208", instr_ID, pc_ID, im_addr, mem(32'h204)); end
    tick(); tick();
    checks++; if (instr_ID !== mem(32'h208) || pc_ID !== 32'h208) begin errors++; $display("FAIL lu_resume: got %h@%h exp %h@208", instr_ID, pc_ID, mem(32'h208)); end
  endtask

  task automatic test_ready_low();
    im_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (im_req_valid !== 1'b1 || im_addr !== 32'h20C || fetch_stall !== 1'b1) begin errors++; $display("FAIL rdy_hold%0d: got v=%b a=%h stall=%b exp 1 20c 1", i, im_req_valid, im_addr, fetch_stall); end
    end
    checks++; if (perf_stall !== exp_stall) begin errors++; $display("FAIL perf_stall: got %0d exp %0d", perf_stall, exp_stall); end
    im_req_ready = 1'b1;
    tick(); tick();
    checks++; if (instr_ID !== mem(32'h20C) || pc_ID !== 32'h20C) begin errors++; $display("FAIL rdy_resume: got %h@%h exp %h@20c", instr_ID, pc_ID, mem(32'h20C)); end
  endtask

  task automatic test_wrap();
    pc_sel = 2'b01; target_pc = 32'hFFFF_FFFF;  // request 210 accepted in same cycle
    tick();
    pc_sel = 2'b00;
    checks++; if (im_req_valid !== 1'b0 || im_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_discard: got v=%b a=%h exp v=0 a=fffffffc", im_req_valid, im_addr); end
    tick(); tick(); tick();
    checks++; if (instr_ID !== mem(32'hFFFF_FFFC) || pc_ID !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_id: got %h@%h exp %h@fffffffc", instr_ID, pc_ID, mem(32'hFFFF_FFFC)); end
    checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h exp 0", im_addr); end
    checks++; if (perf_fetch !== exp_fetch) begin errors++; $display("FAIL perf_fetch: got %0d exp %0d", perf_fetch, exp_fetch); end
    checks++; if (perf_discard !== exp_discard) begin errors++; $display("FAIL perf_discard: got %0d exp %0d", perf_discard, exp_discard); end
  endtask

  task automatic test_reset_mid();
    tick();  // request 0 accepted, response in flight
    rst = 1'b0;
    tick();
    checks++; if (instr_ID !== NOP_W || pc_ID !== 32'h0 || im_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_state: got %h@%h v=%b exp %h@0 v=0", instr_ID, pc_ID, im_req_valid, NOP_W); end
    checks++; if (perf_discard !== 32'h0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL rmid_clear: got disc=%0d stall=%b exp 0 1", perf_discard, fetch_stall); end
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (instr_ID !== mem(32'h0) || pc_ID !== 32'h0 || im_addr !== 32'h4) begin errors++; $display("FAIL rmid_refetch: got %h@%h a=%h exp %h@0 a=4", instr_ID, pc_ID, im_addr, mem(32'h0)); end
  endtask

  initial begin
`ifdef FETCH_PERF_CNT_EN
    exp_stall = 32'd17; exp_fetch = 32'd8; exp_discard = 32'd3;
`else
    exp_stall = 32'd0;  exp_fetch = 32'd0; exp_discard = 32'd0;
`endif
    test_reset();
    test_fetch();
    test_redirect();
    test_pipe_stall();
    test_load_use();
    test_ready_low();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
